// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with DEPTH stages, stall/flush control and a
// forwarding lookup over every in-flight entry (youngest match wins).
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_dest_addr,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_dest_data,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_hilo_hit,
    output logic [DATA_W-1:0] fwd_hi,
    output logic [DATA_W-1:0] fwd_lo,
    output logic [ADDR_W-1:0] wb_dest_addr,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_dest_data,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : gen_bad_depth
            $error("mem_wb_pipe: DEPTH must be in 1..4");
        end
    endgenerate

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  wreg_q;
    logic [DEPTH-1:0]  whilo_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] hi_q   [DEPTH];
    logic [DATA_W-1:0] lo_q   [DEPTH];

    // Stage 0 is youngest. A held WB stage freezes the whole pipe, which also
    // covers the stall_wb-without-stall_mem combination ctrl never issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                wreg_q[k]  <= 1'b0;
                whilo_q[k] <= 1'b0;
                addr_q[k]  <= '0;
                data_q[k]  <= '0;
                hi_q[k]    <= '0;
                lo_q[k]    <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                wreg_q[k]  <= 1'b0;
                whilo_q[k] <= 1'b0;
                addr_q[k]  <= '0;
                data_q[k]  <= '0;
                hi_q[k]    <= '0;
                lo_q[k]    <= '0;
            end
        end else if (!stall_wb) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                valid_q[k] <= valid_q[k-1];
                wreg_q[k]  <= wreg_q[k-1];
                whilo_q[k] <= whilo_q[k-1];
                addr_q[k]  <= addr_q[k-1];
                data_q[k]  <= data_q[k-1];
                hi_q[k]    <= hi_q[k-1];
                lo_q[k]    <= lo_q[k-1];
            end
            if (stall_mem) begin
                valid_q[0] <= 1'b0;
                wreg_q[0]  <= 1'b0;
                whilo_q[0] <= 1'b0;
                addr_q[0]  <= '0;
                data_q[0]  <= '0;
                hi_q[0]    <= '0;
                lo_q[0]    <= '0;
            end else begin
                valid_q[0] <= 1'b1;
                wreg_q[0]  <= mem_wreg;
                whilo_q[0] <= mem_whilo;
                addr_q[0]  <= mem_dest_addr;
                data_q[0]  <= mem_dest_data;
                hi_q[0]    <= mem_hi;
                lo_q[0]    <= mem_lo;
            end
        end
    end

    // Scan oldest to youngest so the youngest matching stage overwrites last.
    always_comb begin
        fwd_hit      = 1'b0;
        fwd_data     = '0;
        fwd_hilo_hit = 1'b0;
        fwd_hi       = '0;
        fwd_lo       = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (valid_q[k] && wreg_q[k] && (addr_q[k] == fwd_addr) && (fwd_addr != '0)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[k];
            end
            if (valid_q[k] && whilo_q[k]) begin
                fwd_hilo_hit = 1'b1;
                fwd_hi       = hi_q[k];
                fwd_lo       = lo_q[k];
            end
        end
    end

    assign wb_dest_addr = addr_q[DEPTH-1];
    assign wb_wreg      = wreg_q[DEPTH-1] & valid_q[DEPTH-1];
    assign wb_dest_data = data_q[DEPTH-1];
    assign wb_hi        = hi_q[DEPTH-1];
    assign wb_lo        = lo_q[DEPTH-1];
    assign wb_whilo     = whilo_q[DEPTH-1] & valid_q[DEPTH-1];

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe: DEPTH=1..4 instances share one directed stimulus
// stream; a per-instance monitor scoreboards every write emerging on wb_*.
module tb_mem_wb_pipe;

    localparam int NDUT = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic        wreg;
        logic [31:0] data;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        int          adv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_dest_addr;
    logic        mem_wreg;
    logic [31:0] mem_dest_data;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic        stall_mem;
    logic        stall_wb;
    logic        flush;
    logic [4:0]  fwd_addr;

    logic        fwd_hit_v      [NDUT];
    logic [31:0] fwd_data_v     [NDUT];
    logic        fwd_hilo_hit_v [NDUT];
    logic [31:0] fwd_hi_v       [NDUT];
    logic [31:0] fwd_lo_v       [NDUT];
    logic [4:0]  wb_dest_addr_v [NDUT];
    logic        wb_wreg_v      [NDUT];
    logic [31:0] wb_dest_data_v [NDUT];
    logic [31:0] wb_hi_v        [NDUT];
    logic [31:0] wb_lo_v        [NDUT];
    logic        wb_whilo_v     [NDUT];

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   adv_cnt      = 0;
    bit   last_adv     = 1'b1;
    exp_t exp_q [NDUT][$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        mem_wb_pipe #(
            .DATA_W(32),
            .ADDR_W(5),
            .DEPTH (g + 1)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .mem_dest_addr(mem_dest_addr),
            .mem_wreg     (mem_wreg),
            .mem_dest_data(mem_dest_data),
            .mem_hi       (mem_hi),
            .mem_lo       (mem_lo),
            .mem_whilo    (mem_whilo),
            .stall_mem    (stall_mem),
            .stall_wb     (stall_wb),
            .flush        (flush),
            .fwd_addr     (fwd_addr),
            .fwd_hit      (fwd_hit_v[g]),
            .fwd_data     (fwd_data_v[g]),
            .fwd_hilo_hit (fwd_hilo_hit_v[g]),
            .fwd_hi       (fwd_hi_v[g]),
            .fwd_lo       (fwd_lo_v[g]),
            .wb_dest_addr (wb_dest_addr_v[g]),
            .wb_wreg      (wb_wreg_v[g]),
            .wb_dest_data (wb_dest_data_v[g]),
            .wb_hi        (wb_hi_v[g]),
            .wb_lo        (wb_lo_v[g]),
            .wb_whilo     (wb_whilo_v[g])
        );
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of MEM inputs, let the edge take them, then record what
    // the pipeline must eventually deliver on each instance's wb port.
    task automatic applyStimulus(input int a, input bit w, input logic [31:0] d,
                                 input logic [31:0] h, input logic [31:0] l, input bit wh,
                                 input bit sm, input bit sw, input bit fl);
        exp_t e;
        mem_dest_addr = a[4:0];
        mem_wreg      = w;
        mem_dest_data = d;
        mem_hi        = h;
        mem_lo        = l;
        mem_whilo     = wh;
        stall_mem     = sm;
        stall_wb      = sw;
        flush         = fl;
        @(posedge clk);
        if (fl) begin
            for (int g = 0; g < NDUT; g++) exp_q[g].delete();
            adv_cnt++;
            last_adv = 1'b1;
        end else if (sw) begin
            last_adv = 1'b0;
        end else begin
            adv_cnt++;
            last_adv = 1'b1;
            if (!sm && (w || wh)) begin
                e.addr  = a[4:0];
                e.wreg  = w;
                e.data  = d;
                e.hi    = h;
                e.lo    = l;
                e.whilo = wh;
                e.adv   = adv_cnt;
                for (int g = 0; g < NDUT; g++) exp_q[g].push_back(e);
            end
        end
        #1;
    endtask

    task automatic applyNop(input int n);
        repeat (n) applyStimulus(0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkFwd(input int g, input int a, input bit hit, input logic [31:0] d);
        fwd_addr = a[4:0];
        #1;
        checkOutput($sformatf("d%0d fwd addr=%0d hit/data", g + 1, a),
                    128'({fwd_hit_v[g], fwd_data_v[g]}), 128'({hit, d}));
    endtask

    task automatic checkHilo(input int g, input bit hit, input logic [31:0] h, input logic [31:0] l);
        checkOutput($sformatf("d%0d fwd hilo hit/hi/lo", g + 1),
                    128'({fwd_hilo_hit_v[g], fwd_hi_v[g], fwd_lo_v[g]}), 128'({hit, h, l}));
    endtask

    task automatic checkIdle(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            checkOutput($sformatf("%s d%0d wb", tag, g + 1),
                        128'({wb_dest_addr_v[g], wb_wreg_v[g], wb_dest_data_v[g],
                              wb_hi_v[g], wb_lo_v[g], wb_whilo_v[g]}), 128'(0));
            checkOutput($sformatf("%s d%0d fwd", tag, g + 1),
                        128'({fwd_hit_v[g], fwd_hilo_hit_v[g], fwd_data_v[g],
                              fwd_hi_v[g], fwd_lo_v[g]}), 128'(0));
        end
    endtask

    // Monitors: a write seen after an advancing edge must be the next queued
    // entry, arriving after exactly DEPTH-1 further advancing edges; after a
    // held edge the wb port must not have changed at all.
    for (genvar g = 0; g < NDUT; g++) begin : gen_mon
        logic [102:0] cur;
        logic [102:0] prev = '0;
        exp_t         e;
        always @(negedge clk) begin
            if (!rst) begin
                cur = {wb_dest_addr_v[g], wb_wreg_v[g], wb_dest_data_v[g],
                       wb_hi_v[g], wb_lo_v[g], wb_whilo_v[g]};
                if (!last_adv) begin
                    checkOutput($sformatf("d%0d wb hold", g + 1), 128'(cur), 128'(prev));
                end else if (wb_wreg_v[g] || wb_whilo_v[g]) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("d%0d unexpected wb write", g + 1), 128'(cur), 128'(0));
                    end else begin
                        e = exp_q[g].pop_front();
                        checkOutput($sformatf("d%0d wb entry", g + 1), 128'(cur),
                                    128'({e.addr, e.wreg, e.data, e.hi, e.lo, e.whilo}));
                        checkOutput($sformatf("d%0d wb latency", g + 1),
                                    128'(adv_cnt - e.adv), 128'(g));
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin
        rst = 1'b1;
        mem_dest_addr = '0;
        mem_wreg = 1'b0;
        mem_dest_data = '0;
        mem_hi = '0;
        mem_lo = '0;
        mem_whilo = 1'b0;
        stall_mem = 1'b0;
        stall_wb = 1'b0;
        flush = 1'b0;
        fwd_addr = '0;

        @(posedge clk);
        #1;
        checkIdle("during reset");
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkIdle("after reset");

        // Single write through the shallowest pipe.
        applyStimulus(5, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("d1 wb data", 128'(wb_dest_data_v[0]), 128'(32'hDEADBEEF));
        for (int g = 0; g < NDUT; g++) checkFwd(g, 5, 1'b1, 32'hDEADBEEF);
        applyNop(4);

        // Two writes to r7: the younger one must be forwarded.
        applyStimulus(7, 1'b1, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(7, 1'b1, 32'h22, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < NDUT; g++) checkFwd(g, 7, 1'b1, 32'h22);
        checkFwd(2, 8, 1'b0, 32'h0);
        applyNop(1);
        checkOutput("d3 wb first r7", 128'(wb_dest_data_v[2]), 128'(32'h11));
        checkFwd(2, 7, 1'b1, 32'h22);
        checkFwd(0, 7, 1'b0, 32'h0);
        applyNop(1);
        checkOutput("d3 wb second r7", 128'(wb_dest_data_v[2]), 128'(32'h22));
        checkFwd(2, 7, 1'b1, 32'h22);
        applyNop(1);
        checkFwd(2, 7, 1'b0, 32'h0);
        applyNop(2);

        // MEM stall inserts a bubble; full stall freezes wb.
        applyStimulus(3, 1'b1, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4, 1'b1, 32'h44, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(6, 1'b1, 32'h66, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("d2 bubble wb_wreg", 128'(wb_wreg_v[1]), 128'(0));
        checkOutput("d2 bubble wb_whilo", 128'(wb_whilo_v[1]), 128'(0));
        checkFwd(1, 4, 1'b0, 32'h0);
        applyNop(1);
        applyStimulus(9, 1'b1, 32'h99, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(9, 1'b1, 32'h99, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("d2 held wb_dest_addr", 128'(wb_dest_addr_v[1]), 128'(5'd6));
        checkOutput("d2 held wb_dest_data", 128'(wb_dest_data_v[1]), 128'(32'h66));
        checkOutput("d2 held wb_wreg", 128'(wb_wreg_v[1]), 128'(1));
        applyNop(4);

        // Flush with the pipe full, coincident with a new valid input.
        applyStimulus(1, 1'b1, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, 1'b1, 32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 32'h103, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkFwd(3, 1, 1'b1, 32'h101);
        checkFwd(0, 1, 1'b0, 32'h0);
        checkFwd(3, 3, 1'b1, 32'h103);
        applyStimulus(4, 1'b1, 32'h104, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < NDUT; g++) checkFwd(g, 4, 1'b0, 32'h0);
        checkOutput("d4 flushed wb_wreg", 128'(wb_wreg_v[3]), 128'(0));
        checkFwd(3, 3, 1'b0, 32'h0);
        applyNop(4);

        // HI/LO: the younger pair is forwarded, both pairs written in order.
        applyStimulus(0, 1'b0, 32'h0, 32'hA, 32'hB, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 32'h0, 32'hC, 32'hD, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < NDUT; g++) checkHilo(g, 1'b1, 32'hC, 32'hD);
        applyNop(1);
        checkHilo(0, 1'b0, 32'h0, 32'h0);
        checkHilo(3, 1'b1, 32'hC, 32'hD);
        applyNop(4);

        // r0 is never forwarded but still passes through to wb.
        applyStimulus(0, 1'b1, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < NDUT; g++) checkFwd(g, 0, 1'b0, 32'h0);
        checkOutput("d1 r0 wb_wreg", 128'(wb_wreg_v[0]), 128'(1));
        applyNop(4);

        // Asynchronous reset mid-stream.
        applyStimulus(10, 1'b1, 32'hAA, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkFwd(0, 10, 1'b1, 32'hAA);
        #1 rst = 1'b1;
        for (int g = 0; g < NDUT; g++) exp_q[g].delete();
        #1;
        checkIdle("async reset");
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkIdle("after async reset");
        applyNop(4);

        for (int g = 0; g < NDUT; g++)
            checkOutput($sformatf("d%0d entries never delivered", g + 1),
                        128'(exp_q[g].size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
